// File: rtl/matrix_nxn_generate_if.sv
// Pixel-stream / window bus between a pixel source and matrix_nxn_generate.
// Defining MATRIX_POS_EN adds the window-centre coordinates matrix_x / matrix_y.
interface matrix_nxn_generate_if #(
    parameter int DATA_W = 8,
    parameter int IMG_W  = 640,
    parameter int WIN    = 3
);
    logic                       pre_vsync;
    logic                       pre_href;
    logic                       wr_en;
    logic [DATA_W-1:0]          img_data;
    logic                       matrix_wr_en;
    logic [WIN*WIN*DATA_W-1:0]  matrix_data;
    logic                       line_err;
`ifdef MATRIX_POS_EN
    logic [$clog2(IMG_W)-1:0]   matrix_x;
    logic [15:0]                matrix_y;

    modport master (
        output pre_vsync, pre_href, wr_en, img_data,
        input  matrix_wr_en, matrix_data, line_err, matrix_x, matrix_y
    );
    modport slave (
        input  pre_vsync, pre_href, wr_en, img_data,
        output matrix_wr_en, matrix_data, line_err, matrix_x, matrix_y
    );
`else
    modport master (
        output pre_vsync, pre_href, wr_en, img_data,
        input  matrix_wr_en, matrix_data, line_err
    );
    modport slave (
        input  pre_vsync, pre_href, wr_en, img_data,
        output matrix_wr_en, matrix_data, line_err
    );
`endif
endinterface

// File: rtl/matrix_nxn_generate.sv
// WIN x WIN sliding-window generator: WIN-1 line buffers feed WIN column shift rows.
// Optional MATRIX_POS_EN adds window-centre coordinates and a 16-bit row counter.
module matrix_nxn_generate #(
    parameter int DATA_W = 8,
    parameter int IMG_W  = 640,
    parameter int WIN    = 3
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst_n,
    matrix_nxn_generate_if.slave bus
);
    localparam int CW   = $clog2(IMG_W);
    localparam int HALF = (WIN - 1) / 2;
`ifdef MATRIX_POS_EN
    localparam int RW   = 16;
`else
    localparam int RW   = $clog2(WIN);
`endif

    genvar gi;

    if ((WIN % 2) == 0 || WIN < 3 || WIN > 7 || IMG_W < WIN) begin : g_param_check
        $error("matrix_nxn_generate: WIN must be odd in 3..7 and IMG_W >= WIN");
    end

    logic                                 pix_vld;
    logic                                 acc;
    logic                                 href_d_reg;
    logic                                 href_fall;
    logic                                 win_due;
    logic [CW-1:0]                        col_cnt_reg;
    logic [RW-1:0]                        row_cnt_reg;
    logic [RW-1:0]                        row_next;
    logic                                 line_err_reg;
    logic                                 matrix_wr_en_reg;
    logic [WIN-2:0][DATA_W-1:0]           tap;
    logic [WIN-2:0][DATA_W-1:0]           lb_in;
    logic [WIN-1:0][DATA_W-1:0]           row_in;
    logic [WIN-1:0][WIN-1:0][DATA_W-1:0]  win_reg;

    assign pix_vld   = bus.pre_href & bus.wr_en;
    // vsync wins over a coincident pixel strobe
    assign acc       = pix_vld & ~bus.pre_vsync;
    assign href_fall = href_d_reg & ~bus.pre_href;
    assign win_due   = (col_cnt_reg >= CW'(WIN - 1)) && (row_cnt_reg >= RW'(WIN - 1));

`ifdef MATRIX_POS_EN
    assign row_next = row_cnt_reg + 1'b1;
`else
    assign row_next = (row_cnt_reg == RW'(WIN - 1)) ? row_cnt_reg : row_cnt_reg + 1'b1;
`endif

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            href_d_reg   <= 1'b0;
            col_cnt_reg  <= '0;
            row_cnt_reg  <= '0;
            line_err_reg <= 1'b0;
        end else begin
            href_d_reg <= bus.pre_href;
            if (bus.pre_vsync) begin
                col_cnt_reg  <= '0;
                row_cnt_reg  <= '0;
                line_err_reg <= 1'b0;
            end else if (acc) begin
                if (col_cnt_reg == CW'(IMG_W - 1)) begin
                    col_cnt_reg <= '0;
                    row_cnt_reg <= row_next;
                end else begin
                    col_cnt_reg <= col_cnt_reg + 1'b1;
                end
            end else if (href_fall && col_cnt_reg != '0) begin
                // line ended early: start the next line and flag it
                col_cnt_reg  <= '0;
                row_cnt_reg  <= row_next;
                line_err_reg <= 1'b1;
            end
        end
    end

    // Line buffer k holds the line k+1 lines above the current one; read-before-write.
    for (gi = 0; gi < WIN - 1; gi++) begin : g_lb
        logic [DATA_W-1:0] mem [IMG_W];

        if (gi == 0) begin : g_head
            assign lb_in[gi] = bus.img_data;
        end else begin : g_chain
            assign lb_in[gi] = tap[gi-1];
        end

        assign tap[gi] = mem[col_cnt_reg];

        always_ff @(posedge sys_clk) begin
            if (acc) begin
                mem[col_cnt_reg] <= lb_in[gi];
            end
        end
    end

    for (gi = 0; gi < WIN; gi++) begin : g_row_in
        if (gi == WIN - 1) begin : g_newest
            assign row_in[gi] = bus.img_data;
        end else begin : g_tap
            assign row_in[gi] = tap[WIN-2-gi];
        end
    end

    // Column index WIN-1 is the newest pixel of each row, so shift towards index 0.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            win_reg <= '0;
        end else if (acc) begin
            for (int r = 0; r < WIN; r++) begin
                win_reg[r] <= {row_in[r], win_reg[r][WIN-1:1]};
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            matrix_wr_en_reg <= 1'b0;
`ifdef MATRIX_POS_EN
            bus.matrix_x     <= '0;
            bus.matrix_y     <= '0;
`endif
        end else if (bus.pre_vsync) begin
            matrix_wr_en_reg <= 1'b0;
`ifdef MATRIX_POS_EN
            bus.matrix_x     <= '0;
            bus.matrix_y     <= '0;
`endif
        end else begin
            matrix_wr_en_reg <= acc & win_due;
`ifdef MATRIX_POS_EN
            if (acc) begin
                bus.matrix_x <= col_cnt_reg - CW'(HALF);
                bus.matrix_y <= row_cnt_reg - 16'(HALF);
            end
`endif
        end
    end

    assign bus.matrix_wr_en = matrix_wr_en_reg;
    assign bus.matrix_data  = win_reg;
    assign bus.line_err     = line_err_reg;

endmodule

// File: tb/tb_matrix_nxn_generate.sv
// Scoreboard bench for matrix_nxn_generate (DATA_W=8, IMG_W=7, WIN=3); compile with
// MATRIX_POS_EN defined to also check the window-centre coordinates.
module tb_matrix_nxn_generate;
    localparam int DATA_W = 8;
    localparam int IMG_W  = 7;
    localparam int WIN    = 3;
    localparam int MW     = WIN * WIN * DATA_W;
    localparam int HALF   = (WIN - 1) / 2;
    localparam int XW     = $clog2(IMG_W);

    logic sys_clk   = 1'b0;
    logic sys_rst_n = 1'b0;

    matrix_nxn_generate_if #(.DATA_W(DATA_W), .IMG_W(IMG_W), .WIN(WIN)) bus_if ();

    matrix_nxn_generate #(.DATA_W(DATA_W), .IMG_W(IMG_W), .WIN(WIN)) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .bus       (bus_if)
    );

    always #5 sys_clk = ~sys_clk;

    int n_checks = 0;
    int n_fail   = 0;
    int win_cnt  = 0;
    logic [MW-1:0] last_win = '0;

    logic [MW-1:0] exp_data_q [$];
    int            exp_x_q    [$];
    int            exp_y_q    [$];

    // Per-column history of accepted pixels, newest at index 0.
    logic [DATA_W-1:0] hist [IMG_W][WIN];
    int   m_col = 0;
    int   m_row = 0;
    logic m_href_prev = 1'b0;

    function automatic logic [MW-1:0] exp_win(input int top, input int left);
        logic [MW-1:0] v;
        v = '0;
        for (int r = 0; r < WIN; r++)
            for (int c = 0; c < WIN; c++)
                v[(r*WIN+c)*DATA_W +: DATA_W] = DATA_W'((top + r) * IMG_W + left + c);
        return v;
    endfunction

    // One clock of stimulus; the model predicts the window, the DUT output is checked after the edge.
    task automatic drive_cycle(input logic vs, input logic h, input logic w, input logic [DATA_W-1:0] d);
        logic [MW-1:0] e;
        logic          exp_pulse;
        int            ex, ey;
        bus_if.pre_vsync = vs;
        bus_if.pre_href  = h;
        bus_if.wr_en     = w;
        bus_if.img_data  = d;
        if (vs) begin
            m_col = 0;
            m_row = 0;
        end else if (h && w) begin
            for (int k = WIN - 1; k > 0; k--) hist[m_col][k] = hist[m_col][k-1];
            hist[m_col][0] = d;
            if (m_col >= WIN - 1 && m_row >= WIN - 1) begin
                e = '0;
                for (int r = 0; r < WIN; r++)
                    for (int c = 0; c < WIN; c++)
                        e[(r*WIN+c)*DATA_W +: DATA_W] = hist[m_col-(WIN-1)+c][WIN-1-r];
                exp_data_q.push_back(e);
                exp_x_q.push_back(m_col - HALF);
                exp_y_q.push_back((m_row - HALF) & 16'hFFFF);
            end
            if (m_col == IMG_W - 1) begin
                m_col = 0;
                m_row++;
            end else begin
                m_col++;
            end
        end else if (m_href_prev && !h && m_col != 0) begin
            m_col = 0;
            m_row++;
        end
        m_href_prev = h;
        @(posedge sys_clk);
        #1;
        exp_pulse = (exp_data_q.size() != 0);
        n_checks++;
        if (bus_if.matrix_wr_en !== exp_pulse) begin
            n_fail++;
            $display("FAIL pulse: matrix_wr_en=%b required %b (t=%0t)", bus_if.matrix_wr_en, exp_pulse, $time);
        end
        if (bus_if.matrix_wr_en === 1'b1) begin
            win_cnt++;
            last_win = bus_if.matrix_data;
        end
        if (exp_pulse) begin
            e  = exp_data_q.pop_front();
            ex = exp_x_q.pop_front();
            ey = exp_y_q.pop_front();
            if (bus_if.matrix_wr_en === 1'b1) begin
                n_checks++;
                if (bus_if.matrix_data !== e) begin
                    n_fail++;
                    $display("FAIL window_data: got %h required %h", bus_if.matrix_data, e);
                end
`ifdef MATRIX_POS_EN
                n_checks++;
                if (bus_if.matrix_x !== XW'(ex) || bus_if.matrix_y !== 16'(ey)) begin
                    n_fail++;
                    $display("FAIL window_pos: got x=%0d y=%0d required x=%0d y=%0d",
                             bus_if.matrix_x, bus_if.matrix_y, ex, ey);
                end
`endif
            end
        end
    endtask

    task automatic test_reset();
        bus_if.pre_vsync = 1'b0;
        bus_if.pre_href  = 1'b0;
        bus_if.wr_en     = 1'b0;
        bus_if.img_data  = '0;
        sys_rst_n = 1'b0;
        repeat (2) @(posedge sys_clk);
        #1;
        m_col = 0; m_row = 0; m_href_prev = 1'b0;
        n_checks++;
        if (bus_if.matrix_wr_en !== 1'b0) begin
            n_fail++; $display("FAIL reset_wr_en: got %b required 0", bus_if.matrix_wr_en);
        end
        n_checks++;
        if (bus_if.matrix_data !== '0) begin
            n_fail++; $display("FAIL reset_data: got %h required 0", bus_if.matrix_data);
        end
        n_checks++;
        if (bus_if.line_err !== 1'b0) begin
            n_fail++; $display("FAIL reset_line_err: got %b required 0", bus_if.line_err);
        end
`ifdef MATRIX_POS_EN
        n_checks++;
        if (bus_if.matrix_x !== '0 || bus_if.matrix_y !== '0) begin
            n_fail++; $display("FAIL reset_pos: got x=%0d y=%0d required 0", bus_if.matrix_x, bus_if.matrix_y);
        end
`endif
        sys_rst_n = 1'b1;
    endtask

    task automatic test_first_window();
        drive_cycle(1'b1, 1'b0, 1'b0, '0);
        drive_cycle(1'b1, 1'b0, 1'b0, '0);
        win_cnt = 0;
        for (int p = 0; p <= 16; p++) begin
            drive_cycle(1'b0, 1'b1, 1'b1, DATA_W'(p));
            drive_cycle(1'b0, 1'b1, 1'b0, '0);
        end
        n_checks++;
        if (win_cnt !== 1) begin
            n_fail++; $display("FAIL first_window_count: got %0d required 1", win_cnt);
        end
        n_checks++;
        if (last_win !== exp_win(0, 0)) begin
            n_fail++; $display("FAIL first_window_data: got %h required %h", last_win, exp_win(0, 0));
        end
        drive_cycle(1'b0, 1'b1, 1'b1, DATA_W'(17));
        n_checks++;
        if (last_win !== exp_win(0, 1)) begin
            n_fail++; $display("FAIL second_window_data: got %h required %h", last_win, exp_win(0, 1));
        end
        $display("first_window: windows=%0d", win_cnt);
    endtask

    task automatic test_frame();
        drive_cycle(1'b0, 1'b1, 1'b0, '0);
        for (int p = 18; p <= 48; p++) begin
            drive_cycle(1'b0, 1'b1, 1'b1, DATA_W'(p));
            drive_cycle(1'b0, 1'b1, 1'b0, '0);
        end
        n_checks++;
        if (win_cnt !== 25) begin
            n_fail++; $display("FAIL frame_count: got %0d required 25", win_cnt);
        end
        n_checks++;
        if (last_win !== exp_win(4, 4)) begin
            n_fail++; $display("FAIL frame_last_window: got %h required %h", last_win, exp_win(4, 4));
        end
        $display("frame: windows=%0d", win_cnt);
    endtask

    task automatic test_short_line();
        drive_cycle(1'b1, 1'b0, 1'b0, '0);
        for (int p = 0; p < IMG_W; p++) drive_cycle(1'b0, 1'b1, 1'b1, DATA_W'($urandom));
        drive_cycle(1'b0, 1'b0, 1'b0, '0);
        for (int p = 0; p < 4; p++) drive_cycle(1'b0, 1'b1, 1'b1, DATA_W'($urandom));
        repeat (3) drive_cycle(1'b0, 1'b0, 1'b0, '0);
        n_checks++;
        if (bus_if.line_err !== 1'b1) begin
            n_fail++; $display("FAIL short_line_err: got %b required 1", bus_if.line_err);
        end
        win_cnt = 0;
        for (int l = 0; l < 2; l++) begin
            for (int p = 0; p < IMG_W; p++) drive_cycle(1'b0, 1'b1, 1'b1, DATA_W'($urandom));
            drive_cycle(1'b0, 1'b0, 1'b0, '0);
        end
        n_checks++;
        if (win_cnt !== 2 * (IMG_W - WIN + 1)) begin
            n_fail++; $display("FAIL short_line_windows: got %0d required %0d", win_cnt, 2 * (IMG_W - WIN + 1));
        end
        n_checks++;
        if (bus_if.line_err !== 1'b1) begin
            n_fail++; $display("FAIL short_line_sticky: got %b required 1", bus_if.line_err);
        end
        $display("short_line: windows=%0d line_err=%b", win_cnt, bus_if.line_err);
    endtask

    task automatic test_vsync_mid();
        for (int p = 0; p < 3; p++) drive_cycle(1'b0, 1'b1, 1'b1, DATA_W'($urandom));
        win_cnt = 0;
        repeat (3) drive_cycle(1'b1, 1'b1, 1'b1, DATA_W'($urandom));
        n_checks++;
        if (bus_if.line_err !== 1'b0) begin
            n_fail++; $display("FAIL vsync_line_err: got %b required 0", bus_if.line_err);
        end
        for (int p = 0; p < 2 * IMG_W + 2; p++) drive_cycle(1'b0, 1'b1, 1'b1, DATA_W'($urandom));
        n_checks++;
        if (win_cnt !== 0) begin
            n_fail++; $display("FAIL vsync_early_window: got %0d required 0", win_cnt);
        end
        drive_cycle(1'b0, 1'b1, 1'b1, DATA_W'($urandom));
        n_checks++;
        if (win_cnt !== 1) begin
            n_fail++; $display("FAIL vsync_first_window: got %0d required 1", win_cnt);
        end
        $display("vsync_mid: windows=%0d", win_cnt);
    endtask

    task automatic test_reset_mid();
        for (int p = 0; p < 3; p++) drive_cycle(1'b0, 1'b1, 1'b1, DATA_W'($urandom));
        test_reset();
        win_cnt = 0;
        for (int p = 0; p <= 16; p++) begin
            drive_cycle(1'b0, 1'b1, 1'b1, DATA_W'(p));
            drive_cycle(1'b0, 1'b1, 1'b0, '0);
        end
        n_checks++;
        if (win_cnt !== 1) begin
            n_fail++; $display("FAIL reset_mid_count: got %0d required 1", win_cnt);
        end
        n_checks++;
        if (last_win !== exp_win(0, 0)) begin
            n_fail++; $display("FAIL reset_mid_window: got %h required %h", last_win, exp_win(0, 0));
        end
        $display("reset_mid: windows=%0d", win_cnt);
    endtask

    task automatic test_back_to_back();
        drive_cycle(1'b1, 1'b0, 1'b0, '0);
        win_cnt = 0;
        for (int p = 0; p < IMG_W * IMG_W; p++) drive_cycle(1'b0, 1'b1, 1'b1, DATA_W'($urandom));
        drive_cycle(1'b0, 1'b0, 1'b0, '0);
        n_checks++;
        if (win_cnt !== 25) begin
            n_fail++; $display("FAIL back_to_back_count: got %0d required 25", win_cnt);
        end
        $display("back_to_back: windows=%0d", win_cnt);
    endtask

    initial begin
        test_reset();
        $display("reset: wr_en=%b line_err=%b", bus_if.matrix_wr_en, bus_if.line_err);
        test_first_window();
        test_frame();
        test_short_line();
        test_vsync_mid();
        test_reset_mid();
        test_back_to_back();
        n_checks++;
        if (exp_data_q.size() != 0) begin
            n_fail++; $display("FAIL scoreboard_drain: got %0d pending required 0", exp_data_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
